dcache_miss_ctrl: RTL

//  MEM-stage controller sitting directly upstream of the 4-way/2-word-line data cache.
//  - Consumes the cache's hit/read-data; on a read miss stalls the pipeline and fetches the 2-word line from main memory.
//  - Fetch uses a req/ack handshake with variable latency; the line is delivered to the cache as one refill write.
//  - Stores are write-through, no-write-allocate; a store that hits also updates the cached word.

---
 rtl/dcache_miss_ctrl_if.sv | 43 ++++
 rtl/dcache_miss_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl_if.sv
// Bundle of the CPU/MEM-stage, cache and main-memory signals around dcache_miss_ctrl.
// master : environment side (pipeline, cache arrays, memory) - drives requests, sees results.
// slave  : the miss controller itself.
// Groups: cpu_* pipeline access, cache_* lookup result, mem_* memory handshake,
//         refill_* line write to the cache, upd_* store-hit word update, err sticky timeout.
interface dcache_miss_ctrl_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned IDX_W = 3
);
    logic             cpu_req;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cache_hit;
    logic [31:0]      cache_rdata;
    logic             stall;
    logic [31:0]      cpu_rdata;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic             refill_valid;
    logic [IDX_W-1:0] refill_index;
    logic [TAG_W-1:0] refill_tag;
    logic [63:0]      refill_data;
    logic             upd_valid;
    logic [31:0]      upd_wdata;
    logic             err;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ack, mem_rdata,
        input  stall, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, refill_valid,
        input  refill_index, refill_tag, refill_data, upd_valid, upd_wdata, err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ack, mem_rdata,
        output stall, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, refill_valid,
        output refill_index, refill_tag, refill_data, upd_valid, upd_wdata, err
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// MEM-stage miss controller for a 4-way, 2-word-line data cache.
// Load hits are served combinationally; load misses stall and fetch the line in two
// req/ack beats, then write it to the cache with one refill pulse. Stores are
// write-through, no-write-allocate; a store hit also pulses upd_valid.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - dcache_miss_ctrl_if.slave (cpu_*, cache_*, mem_*, refill_*, upd_*, err)
// Optional feature: define DCACHE_WRITE_BUFFER_EN for a one-entry store buffer that
// lets a store retire without stalling while it drains to memory in the background.
module dcache_miss_ctrl #(
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    dcache_miss_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD0, RD1, FILL, RESP, WR} state_t;

`ifdef DCACHE_WRITE_BUFFER_EN
    // A buffered store has no pipeline waiting on it, so the drain returns straight to IDLE.
    localparam state_t WR_DONE = IDLE;
`else
    localparam state_t WR_DONE = RESP;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_word0;
    logic [31:0]      r_word1;
    logic [31:0]      r_resp_rdata;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_refill_valid;
    logic             r_err;

    logic w_load;
    logic w_store;
    logic w_miss;
    logic w_serve;
    logic w_store_ok;
    logic w_timeout;
    logic w_unused_addr;

    assign w_load  = bus.cpu_req & ~bus.cpu_we;
    assign w_store = bus.cpu_req & bus.cpu_we;
    assign w_miss  = w_load & ~bus.cache_hit;

`ifdef DCACHE_WRITE_BUFFER_EN
    // While the buffer drains (WR) the pipeline keeps running on hits.
    assign w_serve    = (r_state == IDLE) | (r_state == WR);
    assign w_store_ok = (r_state == IDLE);
`else
    assign w_serve    = (r_state == IDLE);
    assign w_store_ok = 1'b0;
`endif

    // Beat gives up after MEM_TIMEOUT request cycles; an ack on the last one still counts.
    assign w_timeout = ~bus.mem_ack & (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Byte offset within a word carries no meaning for a word-wide cache.
    assign w_unused_addr = ^bus.cpu_addr[1:0];

    always_comb begin
        bus.stall     = 1'b1;
        bus.cpu_rdata = '0;
        if (w_serve) begin
            bus.stall = w_miss | (w_store & ~w_store_ok);
            if (w_load & bus.cache_hit) begin
                bus.cpu_rdata = bus.cache_rdata;
            end
        end else if (r_state == RESP) begin
            bus.stall     = 1'b0;
            bus.cpu_rdata = r_resp_rdata;
        end
    end

    assign bus.upd_valid    = (r_state == IDLE) & w_store & bus.cache_hit;
    assign bus.upd_wdata    = bus.upd_valid ? bus.cpu_wdata : 32'h0;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.refill_valid = r_refill_valid;
    assign bus.refill_index = r_idx;
    assign bus.refill_tag   = r_tag;
    assign bus.refill_data  = {r_word1, r_word0};
    assign bus.err          = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_sel          <= 1'b0;
            r_idx          <= '0;
            r_tag          <= '0;
            r_word0        <= '0;
            r_word1        <= '0;
            r_resp_rdata   <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_refill_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_refill_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_miss) begin
                        r_sel      <= bus.cpu_addr[2];
                        r_idx      <= bus.cpu_addr[3 +: IDX_W];
                        r_tag      <= bus.cpu_addr[3 + IDX_W +: TAG_W];
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {bus.cpu_addr[31:3], 3'b000};
                        r_state    <= RD0;
                    end else if (w_store) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {bus.cpu_addr[31:2], 2'b00};
                        r_mem_wdata <= bus.cpu_wdata;
                        r_state     <= WR;
                    end
                end
                RD0: begin
                    if (bus.mem_ack) begin
                        // mem_req stays high straight into the second beat.
                        r_word0    <= bus.mem_rdata;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        r_cnt      <= '0;
                        r_state    <= RD1;
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_mem_addr   <= '0;
                        r_resp_rdata <= '0;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RD1: begin
                    if (bus.mem_ack) begin
                        r_word1        <= bus.mem_rdata;
                        r_mem_req      <= 1'b0;
                        r_mem_addr     <= '0;
                        r_refill_valid <= 1'b1;
                        r_resp_rdata   <= r_sel ? bus.mem_rdata : r_word0;
                        r_state        <= FILL;
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_mem_addr   <= '0;
                        r_resp_rdata <= '0;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FILL: begin
                    r_state <= RESP;
                end
                RESP: begin
                    // Held request is deliberately not re-examined here.
                    r_resp_rdata <= '0;
                    r_state      <= IDLE;
                end
                WR: begin
                    if (bus.mem_ack || w_timeout) begin
                        if (!bus.mem_ack) begin
                            r_err <= 1'b1;
                        end
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_resp_rdata <= '0;
                        r_state      <= WR_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
